vram_arbiter: RTL and testbench

- Shares the single-port tile/video RAM between the CPU and the video fetch path.
- Uses the horizontal/vertical timing already produced by the timing chain: H count, HBLANK, VBLANK and the pixel-clock enable.
- Fixed video slots in each 8-pixel character cell are reserved for tile fetch; the remaining slots, and all of blanking, serve CPU accesses.
- Also owns the VBLANK interrupt flop (nIRQ set at VBLANK entry, cleared by nINTACK).

---
 rtl/vram_arbiter_pkg.sv | 21 ++
 rtl/vram_irq_ctl.sv | 38 +++
 rtl/vram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: slot index width, the default
// video slot reservation and the CPU-side access state encoding.
package vram_arbiter_pkg;

  localparam int SLOT_W = 3;

  localparam logic [7:0] DEFAULT_VID_SLOT_MASK = 8'b0000_0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } arb_state_e;

  // True when the given cell slot is reserved for tile fetch.
  function automatic logic slot_reserved(input logic [7:0] mask,
                                         input logic [SLOT_W-1:0] slot);
    return mask[slot];
  endfunction

endpackage

// File: rtl/vram_irq_ctl.sv
// VBLANK interrupt flop: a rising edge of vblank pulls the active-low
// interrupt low, a sampled low acknowledge releases it. When both occur on
// the same clock the new interrupt wins so no frame is lost.
module vram_irq_ctl (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vblank_i,
  input  logic int_ack_ni,
  output logic irq_no
);

  logic vblank_q;
  logic irq_n_q, irq_n_d;

  // Next interrupt level: set on vblank entry, else cleared by acknowledge.
  always_comb begin
    irq_n_d = irq_n_q;
    if (vblank_i && !vblank_q) begin
      irq_n_d = 1'b0;
    end else if (!int_ack_ni) begin
      irq_n_d = 1'b1;
    end
  end

  // Delayed vblank for edge detection and the interrupt flop itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vblank_q <= 1'b0;
      irq_n_q  <= 1'b1;
    end else begin
      vblank_q <= vblank_i;
      irq_n_q  <= irq_n_d;
    end
  end

  assign irq_no = irq_n_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter. Reserved slots of each 8-pixel character cell
// fetch tiles for video and are never delayed; every other pixel slot, and
// all of blanking, may serve one pending CPU access. The RAM is synchronous,
// so read data is captured one clock after the address was presented.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int         ADDR_W        = 10,
  parameter int         DATA_W        = 8,
  parameter logic [7:0] VID_SLOT_MASK = DEFAULT_VID_SLOT_MASK,
  parameter int         MAX_WAIT      = 15
) (
  input  logic              clk,
  input  logic              nRESET,
  input  logic              pix_en,
  input  logic [SLOT_W-1:0] h_cnt,
  input  logic              hblank,
  input  logic              vblank,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_rdy,
  output logic              cpu_timeout,
  input  logic              nINTACK,
  output logic              nIRQ,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic active;
  logic vid_slot;
  logic cpu_ok;
  logic cpu_issue;

  arb_state_e state_q, state_d;

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  logic              issue_rd_q;
  logic              vid_pend_q;
  logic              vid_valid_q;
  logic [DATA_W-1:0] vid_data_q;
  logic [DATA_W-1:0] cpu_rdata_q;

  logic [ADDR_W-1:0] addr_q, ram_addr_d;
  logic [DATA_W-1:0] wdata_q, ram_wdata_d;

  assign active   = ~hblank & ~vblank;
  assign vid_slot = pix_en & active & slot_reserved(VID_SLOT_MASK, h_cnt);
  assign cpu_ok   = pix_en & ~vid_slot;

  // CPU access FSM: grant on an eligible pixel slot, count slots spent
  // waiting, and block a back-to-back grant during the acknowledge clock.
  always_comb begin
    state_d    = state_q;
    cpu_issue  = 1'b0;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          if (cpu_ok) begin
            cpu_issue = 1'b1;
            state_d   = ST_ACK;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!cpu_req) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (cpu_ok) begin
          cpu_issue  = 1'b1;
          state_d    = ST_ACK;
          wait_cnt_d = '0;
        end else if (pix_en) begin
          if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
          if (wait_cnt_d == WAIT_W'(MAX_WAIT)) begin
            timeout_d = 1'b1;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM port mux: video owns its slots, a CPU issue owns its single clock,
  // otherwise address and write data hold their previous values.
  always_comb begin
    ram_addr_d  = addr_q;
    ram_wdata_d = wdata_q;
    if (vid_slot) begin
      ram_addr_d = vid_addr;
    end else if (cpu_issue) begin
      ram_addr_d  = cpu_addr;
      ram_wdata_d = cpu_wdata;
    end
  end

  // State, wait counter, sticky timeout and RAM port hold registers.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      addr_q     <= ram_addr_d;
      wdata_q    <= ram_wdata_d;
    end
  end

  // Read return path: RAM data arrives the clock after the address, so it
  // is captured one clock after a video slot or a CPU read issue.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      issue_rd_q  <= 1'b0;
      vid_pend_q  <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      issue_rd_q  <= cpu_issue & ~cpu_we;
      vid_pend_q  <= vid_slot;
      vid_valid_q <= vid_pend_q;
      if (vid_pend_q) begin
        vid_data_q <= ram_rdata;
      end
      if ((state_q == ST_ACK) && issue_rd_q) begin
        cpu_rdata_q <= ram_rdata;
      end
    end
  end

  vram_irq_ctl u_irq_ctl (
    .clk_i      (clk),
    .rst_ni     (nRESET),
    .vblank_i   (vblank),
    .int_ack_ni (nINTACK),
    .irq_no     (nIRQ)
  );

  // The RAM strobe, address and RDY are combinational, so they are forced
  // to their idle values while reset is held.
  assign ram_we      = nRESET & cpu_issue & cpu_we;
  assign ram_addr    = nRESET ? ram_addr_d : '0;
  assign ram_wdata   = nRESET ? ram_wdata_d : '0;
  assign cpu_ack     = (state_q == ST_ACK);
  assign cpu_rdy     = ~nRESET | ~(cpu_req & ~cpu_ack);
  assign cpu_timeout = timeout_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign vid_data    = vid_data_q;
  assign vid_valid   = vid_valid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a synchronous RAM model answers the DUT's RAM
// port, and a reference model tracks what every output should be from the
// arbitration rules (video owns reserved active slots, CPU gets any other
// pixel slot, one blocked clock after each acknowledge).
module tb_vram_arbiter;

  localparam int         ADDR_W   = 10;
  localparam int         DATA_W   = 8;
  localparam logic [7:0] MASK     = 8'b0000_0011;
  localparam int         MAX_WAIT = 15;

  logic              clk = 1'b0;
  logic              nRESET = 1'b1;
  logic              pix_en = 1'b0;
  logic [2:0]        h_cnt = 3'd0;
  logic              hblank = 1'b0;
  logic              vblank = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_rdy;
  logic              cpu_timeout;
  logic              nINTACK = 1'b1;
  logic              nIRQ;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always #5 clk = ~clk;

  vram_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .VID_SLOT_MASK (MASK),
    .MAX_WAIT      (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .nRESET      (nRESET),
    .pix_en      (pix_en),
    .h_cnt       (h_cnt),
    .hblank      (hblank),
    .vblank      (vblank),
    .vid_addr    (vid_addr),
    .vid_data    (vid_data),
    .vid_valid   (vid_valid),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdy     (cpu_rdy),
    .cpu_timeout (cpu_timeout),
    .nINTACK     (nINTACK),
    .nIRQ        (nIRQ),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  // Power-up RAM contents are a salted function of the address, shared by
  // the RAM model and the reference memory.
  logic [7:0] memSalt = 8'h00;

  function automatic logic [7:0] initVal(input logic [ADDR_W-1:0] a);
    return 8'(a) ^ 8'(a >> 3) ^ memSalt;
  endfunction

  // Synchronous single-port RAM seen by the DUT: read data is the word at
  // the address presented on the previous clock.
  logic [DATA_W-1:0] ramMem [0:1023];
  bit                ramWritten [0:1023];

  always @(posedge clk) begin
    if (ram_we) begin
      ramMem[ram_addr]     <= ram_wdata;
      ramWritten[ram_addr] <= 1'b1;
    end
    ram_rdata <= ramWritten[ram_addr] ? ramMem[ram_addr] : initVal(ram_addr);
  end

  // Reference model state.
  logic [DATA_W-1:0] refMem [0:1023];
  bit                mAck;
  bit                mAckRead;
  logic [DATA_W-1:0] mAckVal;
  logic [DATA_W-1:0] mRdata;
  bit                mVidPend;
  logic [DATA_W-1:0] mVidPendVal;
  bit                mVidValid;
  logic [DATA_W-1:0] mVidData;
  bit                mInWait;
  int                mWaitCnt;
  bit                mTimeout;
  bit                mIrqN;
  bit                mVblankPrev;
  logic [ADDR_W-1:0] mLastAddr;

  // Stimulus shaping knobs for the timing chain.
  int  pixPeriod = 4;
  int  hWrap     = 8;
  int  tick      = 0;
  bit  randVid   = 1'b0;
  bit  irqRand   = 1'b0;

  int  checks   = 0;
  int  failures = 0;

  // One comparison: counted, and reported with tag and both values on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the timing chain by one clock: the slot index moves on after
  // each pixel strobe, and a fresh tile address appears at each cell start.
  task automatic applyStimulus();
    if (pix_en) begin
      h_cnt = 3'((int'(h_cnt) + 1) % hWrap);
      if (randVid && h_cnt == 3'd0) vid_addr = 10'($urandom_range(0, 1023));
    end
    tick++;
    pix_en  = (tick % pixPeriod) == 0;
    nINTACK = !(irqRand && ($urandom_range(0, 15) == 0));
  endtask

  // Random CPU behaviour: release on acknowledge, occasionally start a new
  // access, and occasionally abandon one that has not been granted yet.
  task automatic cpuRandom(input bit allowDrop);
    if (cpu_ack) begin
      cpu_req = 1'b0;
    end else if (!cpu_req) begin
      if ($urandom_range(0, 2) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 10'($urandom_range(0, 1023));
        cpu_wdata = 8'($urandom_range(0, 255));
      end
    end else if (allowDrop && ($urandom_range(0, 15) == 0)) begin
      cpu_req = 1'b0;
    end
  endtask

  // Run one clock with the inputs already set: check the combinational RAM
  // port and RDY against the rules, advance the model, then check every
  // registered output just after the edge.
  task automatic stepCycle();
    bit                act, vs, expIssue, expRdy, prevAck;
    logic [ADDR_W-1:0] expAddr;
    #1;
    act      = !hblank && !vblank;
    vs       = pix_en && act && MASK[h_cnt];
    prevAck  = mAck;
    expIssue = cpu_req && pix_en && !vs && !prevAck;
    expRdy   = !(cpu_req && !prevAck);
    expAddr  = vs ? vid_addr : (expIssue ? cpu_addr : mLastAddr);
    checkOutput("ram_we", ram_we, expIssue && cpu_we);
    checkOutput("ram_addr", ram_addr, expAddr);
    if (expIssue) checkOutput("ram_wdata", ram_wdata, cpu_wdata);
    checkOutput("cpu_rdy", cpu_rdy, expRdy);

    if (prevAck && mAckRead) mRdata = mAckVal;
    if (expIssue) begin
      mAckRead = !cpu_we;
      mAckVal  = refMem[cpu_addr];
      if (cpu_we) refMem[cpu_addr] = cpu_wdata;
    end
    if (mVidPend) mVidData = mVidPendVal;
    mVidValid = mVidPend;
    mVidPend  = vs;
    if (vs) mVidPendVal = refMem[vid_addr];

    if (mInWait && cpu_req && pix_en && !expIssue) begin
      if (mWaitCnt < MAX_WAIT) mWaitCnt++;
      if (mWaitCnt == MAX_WAIT) mTimeout = 1'b1;
    end
    mInWait = cpu_req && !expIssue && !prevAck;
    if (!mInWait) mWaitCnt = 0;

    if (vblank && !mVblankPrev) mIrqN = 1'b0;
    else if (!nINTACK) mIrqN = 1'b1;
    mVblankPrev = vblank;

    mLastAddr = expAddr;
    mAck      = expIssue;

    @(posedge clk);
    #1;
    checkOutput("cpu_ack", cpu_ack, mAck);
    checkOutput("cpu_rdata", cpu_rdata, mRdata);
    checkOutput("vid_valid", vid_valid, mVidValid);
    checkOutput("vid_data", vid_data, mVidData);
    checkOutput("cpu_timeout", cpu_timeout, mTimeout);
    checkOutput("nIRQ", nIRQ, mIrqN);
  endtask

  // Assert reset (possibly mid-access), check the idle outputs while it is
  // held, and restart the model from its reset state.
  task automatic doReset(input int holdCycles);
    nRESET = 1'b0;
    #1;
    checkOutput("rst_cpu_ack", cpu_ack, 1'b0);
    checkOutput("rst_ram_we", ram_we, 1'b0);
    checkOutput("rst_ram_addr", ram_addr, '0);
    checkOutput("rst_nIRQ", nIRQ, 1'b1);
    checkOutput("rst_cpu_rdy", cpu_rdy, 1'b1);
    checkOutput("rst_vid_valid", vid_valid, 1'b0);
    checkOutput("rst_vid_data", vid_data, '0);
    checkOutput("rst_cpu_rdata", cpu_rdata, '0);
    checkOutput("rst_cpu_timeout", cpu_timeout, 1'b0);
    mAck = 0; mAckRead = 0; mAckVal = '0; mRdata = '0;
    mVidPend = 0; mVidPendVal = '0; mVidValid = 0; mVidData = '0;
    mInWait = 0; mWaitCnt = 0; mTimeout = 0;
    mIrqN = 1; mVblankPrev = 0; mLastAddr = '0;
    repeat (holdCycles) @(posedge clk);
    #1;
    nRESET = 1'b1;
  endtask

  // Keep clocking until the DUT acknowledges, within a fixed budget.
  task automatic waitAck(input string tag);
    for (int n = 0; n < 64 && !cpu_ack; n++) begin
      applyStimulus();
      stepCycle();
    end
    checkOutput(tag, cpu_ack, 1'b1);
  endtask

  // One complete CPU access, optionally raised exactly on a slot-0 strobe.
  task automatic cpuAccess(input bit we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input bit alignSlot0,
                           input string tag);
    applyStimulus();
    if (alignSlot0) begin
      for (int n = 0; n < 64 && !(pix_en && h_cnt == 3'd0); n++) begin
        stepCycle();
        applyStimulus();
      end
    end
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = data;
    stepCycle();
    waitAck(tag);
    cpu_req = 1'b0;
    applyStimulus();
    stepCycle();
  endtask

  // Let any outstanding CPU access finish or be abandoned.
  task automatic drainCpu();
    cpu_req = 1'b0;
    repeat (2) begin
      applyStimulus();
      stepCycle();
    end
  endtask

  // Directed phases with randomized contents, all checked by the model.
  initial begin
    memSalt = 8'($urandom_range(0, 255));
    for (int i = 0; i < 1024; i++) refMem[i] = initVal(10'(i));
    #2;
    doReset(2);

    // Preload the tile word during horizontal blank, then fetch it in
    // active display from the two reserved slots of each cell.
    hblank = 1'b1;
    pixPeriod = 4;
    cpuAccess(1'b1, 10'h155, 8'hA5, 1'b0, "preload_ack");
    hblank = 1'b0;
    vid_addr = 10'h155;
    for (int c = 0; c < 64; c++) begin
      applyStimulus();
      stepCycle();
      if (vid_valid) checkOutput("vid_fetch_155", vid_data, 8'hA5);
    end

    // Write raised on slot 0 waits out the video slots, then read it back.
    cpuAccess(1'b1, 10'h2AA, 8'h3C, 1'b1, "wr_2AA_ack");
    cpuAccess(1'b0, 10'h2AA, 8'h00, 1'b0, "rd_2AA_ack");
    checkOutput("readback_2AA", cpu_rdata, 8'h3C);

    // Random traffic in active display at several pixel rates.
    randVid = 1'b1;
    for (int blk = 0; blk < 6; blk++) begin
      pixPeriod = $urandom_range(1, 4);
      for (int c = 0; c < 50; c++) begin
        applyStimulus();
        cpuRandom(1'b1);
        stepCycle();
      end
    end
    drainCpu();

    // Horizontal blank: every pixel strobe serves the CPU.
    hblank = 1'b1;
    pixPeriod = 3;
    cpuAccess(1'b0, 10'($urandom_range(0, 1023)), 8'h00, 1'b0, "hb_read_ack");
    for (int c = 0; c < 150; c++) begin
      applyStimulus();
      cpuRandom(1'b1);
      stepCycle();
    end
    drainCpu();

    // Every strobe lands on a reserved slot, so the request starves until
    // horizontal blank opens.
    checkOutput("timeout_clear_before", cpu_timeout, 1'b0);
    hblank = 1'b0;
    hWrap = 2;
    pixPeriod = 2;
    h_cnt = 3'd0;
    applyStimulus();
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 10'($urandom_range(0, 1023));
    stepCycle();
    for (int c = 0; c < 40; c++) begin
      applyStimulus();
      stepCycle();
    end
    checkOutput("timeout_set", cpu_timeout, 1'b1);
    hblank = 1'b1;
    waitAck("timeout_hb_ack");
    cpu_req = 1'b0;
    applyStimulus();
    stepCycle();
    hWrap = 8;

    // Interrupt: vblank entry, acknowledge, and entry coinciding with ack.
    hblank = 1'b0;
    vblank = 1'b1;
    applyStimulus();
    stepCycle();
    checkOutput("irq_set", nIRQ, 1'b0);
    applyStimulus();
    stepCycle();
    applyStimulus();
    nINTACK = 1'b0;
    stepCycle();
    checkOutput("irq_ack", nIRQ, 1'b1);
    vblank = 1'b0;
    applyStimulus();
    stepCycle();
    vblank = 1'b1;
    applyStimulus();
    nINTACK = 1'b0;
    stepCycle();
    checkOutput("irq_set_wins", nIRQ, 1'b0);

    // Random frame timing with random acknowledges and CPU traffic.
    irqRand = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if ($urandom_range(0, 15) == 0) vblank = !vblank;
      if ($urandom_range(0, 31) == 0) hblank = !hblank;
      applyStimulus();
      cpuRandom(1'b1);
      stepCycle();
    end
    irqRand = 1'b0;
    drainCpu();

    // Leave the interrupt pending, then reset in the middle of an access.
    vblank = 1'b0;
    applyStimulus();
    stepCycle();
    vblank = 1'b1;
    applyStimulus();
    stepCycle();
    checkOutput("irq_before_reset", nIRQ, 1'b0);
    pixPeriod = 3;
    applyStimulus();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 10'($urandom_range(0, 1023));
    stepCycle();
    waitAck("pre_reset_ack");
    doReset(3);
    waitAck("post_reset_ack");
    cpu_req = 1'b0;
    applyStimulus();
    stepCycle();
    applyStimulus();
    stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
